// File: rtl/mlp_seq_ctrl.sv
// Sequential two-layer MLP classifier sharing one signed MAC unit, one product per cycle.
// Weights and biases are elaboration-time constants; the result is an argmax class index.
module mlp_seq_ctrl #(
  parameter int N_IN  = 11,
  parameter int N_HID = 2,
  parameter int N_OUT = 6,
  parameter int IW    = 4,
  parameter int WW    = 4,
  parameter int BW    = 8,
  parameter int AW    = 14,
  parameter int HW    = 8,
  parameter logic [N_HID*N_IN*WW-1:0]  W0 = '0,
  parameter logic [N_HID*BW-1:0]       B0 = '0,
  parameter logic [N_OUT*N_HID*WW-1:0] W1 = '0,
  parameter logic [N_OUT*BW-1:0]       B1 = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_IN*IW-1:0] inp,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2:0]         out,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int NMAX = (N_OUT > N_HID) ? N_OUT : N_HID;
  localparam int KMAX = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int NW   = $clog2(NMAX);
  localparam int KW   = $clog2(KMAX);

  localparam logic [KW-1:0] K_IN_LAST  = KW'(N_IN - 1);
  localparam logic [KW-1:0] K_HID_LAST = KW'(N_HID - 1);
  localparam logic [NW-1:0] N_HID_LAST = NW'(N_HID - 1);
  localparam logic [NW-1:0] N_OUT_LAST = NW'(N_OUT - 1);

  typedef enum logic [1:0] {IDLE, HID, OUTL, HOLD} state_t;

  state_t               r_state;
  logic [NW-1:0]        r_n;
  logic [KW-1:0]        r_k;
  logic signed [AW-1:0] r_acc;
  logic [AW-1:0]        r_best;
  logic [2:0]           r_idx;
  logic [N_IN*IW-1:0]   r_x;
  logic [N_HID*HW-1:0]  r_hid;
  logic [2:0]           r_out;
  logic                 r_out_valid;

  logic [WW-1:0]        w_wt;
  logic [AW-1:0]        w_op;
  logic signed [AW-1:0] w_term;
  logic signed [AW-1:0] w_sum;
  logic [AW-1:0]        w_relu;
  logic [HW-1:0]        w_hsat;
  logic                 w_better;
  logic [2:0]           w_idx_fin;

  function automatic logic signed [AW-1:0] sext_b(input logic [BW-1:0] b);
    return {{(AW-BW){b[BW-1]}}, b};
  endfunction

  // Operand mux: input features in HID, hidden activations in OUTL.
  always_comb begin
    w_wt = '0;
    w_op = '0;
    if (r_state == OUTL) begin
      w_wt = W1[(int'(r_n) * N_HID + int'(r_k)) * WW +: WW];
      w_op = AW'(r_hid[int'(r_k) * HW +: HW]);
    end else begin
      w_wt = W0[(int'(r_n) * N_IN + int'(r_k)) * WW +: WW];
      w_op = AW'(r_x[int'(r_k) * IW +: IW]);
    end
    w_term    = $signed(w_op) * $signed({{(AW-WW){w_wt[WW-1]}}, w_wt});
    w_sum     = r_acc + w_term;
    w_relu    = w_sum[AW-1] ? '0 : w_sum;
    w_hsat    = (|w_relu[AW-1:HW]) ? {HW{1'b1}} : w_relu[HW-1:0];
    // Strict compare keeps the lower index on ties.
    w_better  = (r_n == '0) || (w_relu > r_best);
    w_idx_fin = w_better ? 3'(r_n) : r_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_n         <= '0;
      r_k         <= '0;
      r_acc       <= '0;
      r_best      <= '0;
      r_idx       <= '0;
      r_x         <= '0;
      r_hid       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x     <= inp;
            r_acc   <= sext_b(B0[BW-1:0]);
            r_n     <= '0;
            r_k     <= '0;
            r_state <= HID;
          end
        end
        HID: begin
          r_acc <= w_sum;
          if (r_k == K_IN_LAST) begin
            r_hid[int'(r_n) * HW +: HW] <= w_hsat;
            r_k <= '0;
            if (r_n == N_HID_LAST) begin
              r_acc   <= sext_b(B1[BW-1:0]);
              r_n     <= '0;
              r_state <= OUTL;
            end else begin
              r_acc <= sext_b(B0[(int'(r_n) + 1) * BW +: BW]);
              r_n   <= r_n + 1'b1;
            end
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        OUTL: begin
          r_acc <= w_sum;
          if (r_k == K_HID_LAST) begin
            r_k <= '0;
            if (w_better) begin
              r_best <= w_relu;
              r_idx  <= 3'(r_n);
            end
            if (r_n == N_OUT_LAST) begin
              r_out       <= w_idx_fin;
              r_out_valid <= 1'b1;
              r_n         <= '0;
              r_state     <= HOLD;
            end else begin
              r_acc <= sext_b(B1[(int'(r_n) + 1) * BW +: BW]);
              r_n   <= r_n + 1'b1;
            end
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule
